// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter
// Write-port arbiter and pending-write scoreboard for the register bank.
// Three writeback sources (0 = ALU, 1 = memory load, 2 = kernel link) each own
// a one-entry holding slot behind a valid/ready handshake. At most one slot is
// granted per cycle, and the grant goes through a registered output stage
// (WE/RD/WB). pend[] flags every register with a write still in flight.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   {alu,mem,lnk}_valid/_rd/_data requester inputs
//   {alu,mem,lnk}_ready           requester may transfer this cycle
//   WE, RD, WB                    registered write port to the bank
//   pend                          per-register pending-write mask
//   pc_wr_err                     sticky: a request targeted the PC index
//   byp_valid, byp_rd, byp_data   forwarding copy of the output stage
//
// Build option: define REGWR_BYPASS_EN to drive byp_* from WE/RD/WB;
// otherwise byp_* are tied to zero.
module regbank_wr_arbiter #(
    parameter int bus = 32,
    parameter int dir = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    input  logic [dir-1:0]      alu_rd,
    input  logic [bus-1:0]      alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [dir-1:0]      mem_rd,
    input  logic [bus-1:0]      mem_data,
    output logic                mem_ready,
    input  logic                lnk_valid,
    input  logic [dir-1:0]      lnk_rd,
    input  logic [bus-1:0]      lnk_data,
    output logic                lnk_ready,
    output logic                WE,
    output logic [dir-1:0]      RD,
    output logic [bus-1:0]      WB,
    output logic [2**dir-1:0]   pend,
    output logic                pc_wr_err,
    output logic                byp_valid,
    output logic [dir-1:0]      byp_rd,
    output logic [bus-1:0]      byp_data
);

    localparam int reg_num = 2**dir;
    localparam logic [dir-1:0] pc_idx = {dir{1'b1}};  // reg_num-1

    // Requester inputs gathered into arrays indexed by requester number.
    logic [2:0]     in_valid;
    logic [dir-1:0] in_rd   [3];
    logic [bus-1:0] in_data [3];

    assign in_valid   = {lnk_valid, mem_valid, alu_valid};
    assign in_rd[0]   = alu_rd;
    assign in_rd[1]   = mem_rd;
    assign in_rd[2]   = lnk_rd;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;
    assign in_data[2] = lnk_data;

    // Slot state. older[a][b] = 1 means slot a was loaded before slot b;
    // it is only meaningful while both slots are full.
    logic [2:0]     slot_full;
    logic [dir-1:0] slot_rd   [3];
    logic [bus-1:0] slot_data [3];
    logic [2:0]     older     [3];
    logic [1:0]     rr;

    logic [1:0]     cand;
    logic           cand_ok;
    logic [2:0]     match;
    logic [2:0]     blocked;
    logic [2:0]     grant;
    logic [1:0]     g;
    logic           any_grant;
    logic [2:0]     ready;
    logic [2:0]     xfer;
    logic [2:0]     pc_hit;
    logic [2:0]     load;
    logic [2:0]     stay;

    function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Grant: round-robin candidate, then the oldest full slot sharing its rd
    // wins so same-register writes leave in acceptance order.
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        cand    = 2'd0;
        cand_ok = 1'b0;
        // Scan from the far end so the nearest full slot after rr wins.
        for (int k = 2; k >= 0; k--) begin
            if (slot_full[wrap3(rr, 2'(k))]) begin
                cand    = wrap3(rr, 2'(k));
                cand_ok = 1'b1;
            end
        end

        match   = '0;
        blocked = '0;
        grant   = '0;
        for (int j = 0; j < 3; j++) begin
            match[j] = cand_ok && slot_full[j] && (slot_rd[j] == slot_rd[cand]);
        end
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                if (k != j && match[k] && older[k][j]) begin
                    blocked[j] = 1'b1;
                end
            end
            grant[j] = match[j] & ~blocked[j];
        end

        g = 2'd0;
        for (int j = 0; j < 3; j++) begin
            if (grant[j]) begin
                g = 2'(j);
            end
        end
    end

    assign any_grant = |grant;

    // Ready is forced low while reset is asserted so nothing transfers into
    // a slot that the same edge is clearing.
    assign ready     = {3{rst_n}} & (~slot_full | grant);
    assign xfer      = in_valid & ready;
    assign stay      = slot_full & ~grant;

    always_comb begin
        pc_hit = '0;
        for (int i = 0; i < 3; i++) begin
            pc_hit[i] = xfer[i] && (in_rd[i] == pc_idx);
        end
    end

    // A PC-targeted request completes its handshake but is dropped.
    assign load = xfer & ~pc_hit;

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];
    assign lnk_ready = ready[2];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_full <= '0;
            rr        <= 2'd0;
            WE        <= 1'b0;
            RD        <= '0;
            WB        <= '0;
            pc_wr_err <= 1'b0;
            for (int a = 0; a < 3; a++) begin
                older[a] <= '0;
            end
        end else begin
            if (any_grant) begin
                WE <= 1'b1;
                RD <= slot_rd[g];
                WB <= slot_data[g];
                rr <= wrap3(g, 2'd1);
            end else begin
                WE <= 1'b0;
            end

            for (int i = 0; i < 3; i++) begin
                if (load[i]) begin
                    slot_full[i] <= 1'b1;
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end

            // A newly loaded slot is younger than every slot still holding a
            // write; among same-edge loads the lower index is older.
            for (int a = 0; a < 3; a++) begin
                for (int b = 0; b < 3; b++) begin
                    if (a != b) begin
                        if (load[b]) begin
                            older[a][b] <= stay[a] | (load[a] & (a < b));
                        end else if (load[a]) begin
                            older[a][b] <= 1'b0;
                        end
                    end
                end
            end

            if (|pc_hit) begin
                pc_wr_err <= 1'b1;
            end
        end
    end

    // NOTE: slot payloads are qualified by slot_full, so they carry no reset;
    // only the control state and the visible outputs are reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (load[i]) begin
                slot_rd[i]   <= in_rd[i];
                slot_data[i] <= in_data[i];
            end
        end
    end

    // Pending mask from registered state only.
    always_comb begin
        pend = '0;
        for (int i = 0; i < 3; i++) begin
            if (slot_full[i]) begin
                pend[slot_rd[i]] = 1'b1;
            end
        end
        if (WE) begin
            pend[RD] = 1'b1;
        end
    end

`ifdef REGWR_BYPASS_EN
    assign byp_valid = WE;
    assign byp_rd    = RD;
    assign byp_data  = WB;
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = '0;
    assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Testbench for regbank_wr_arbiter: randomized and directed traffic checked
// against a slot/timestamp reference model; a monitor compares every emitted
// write against the expected-write queue.
module tb_regbank_wr_arbiter;

    localparam int bus     = 32;
    localparam int dir     = 4;
    localparam int reg_num = 16;

    logic clk = 1'b0;
    logic rst_n;

    logic           v   [3];
    logic [dir-1:0] rdi [3];
    logic [bus-1:0] di  [3];

    logic               alu_ready, mem_ready, lnk_ready;
    logic               we;
    logic [dir-1:0]     rd_o;
    logic [bus-1:0]     wb_o;
    logic [reg_num-1:0] pend;
    logic               pc_wr_err;
    logic               byp_valid;
    logic [dir-1:0]     byp_rd;
    logic [bus-1:0]     byp_data;

    regbank_wr_arbiter #(.bus(bus), .dir(dir)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (v[0]),
        .alu_rd    (rdi[0]),
        .alu_data  (di[0]),
        .alu_ready (alu_ready),
        .mem_valid (v[1]),
        .mem_rd    (rdi[1]),
        .mem_data  (di[1]),
        .mem_ready (mem_ready),
        .lnk_valid (v[2]),
        .lnk_rd    (rdi[2]),
        .lnk_data  (di[2]),
        .lnk_ready (lnk_ready),
        .WE        (we),
        .RD        (rd_o),
        .WB        (wb_o),
        .pend      (pend),
        .pc_wr_err (pc_wr_err),
        .byp_valid (byp_valid),
        .byp_rd    (byp_rd),
        .byp_data  (byp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [dir-1:0] rd;
        logic [bus-1:0] data;
    } wr_t;

    wr_t            exp_q[$];
    int             n_vec = 0;
    int             n_err = 0;
    logic [bus-1:0] bank [reg_num];

    // Reference model: slots with acceptance timestamps, plain integers.
    bit             m_full [3];
    logic [dir-1:0] m_rd   [3];
    logic [bus-1:0] m_data [3];
    int             m_age  [3];
    int             m_seq;
    int             m_rr;
    bit             m_we;
    logic [dir-1:0] m_rdo;
    logic [bus-1:0] m_wb;
    bit             m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 0;
            m_age[i]  = 0;
        end
        m_rr  = 0;
        m_we  = 0;
        m_rdo = '0;
        m_wb  = '0;
        m_err = 0;
    endtask

    // Monitor: every write the bank sees must be the next expected one.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got rd=%0h data=%0h, none expected", rd_o, wb_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_rd", 64'(rd_o), 64'(e.rd));
                check("wr_data", 64'(wb_o), 64'(e.data));
                bank[rd_o] = wb_o;
            end
        end
    end

    // One clock of stimulus: check DUT outputs against the model mid-cycle,
    // then advance the model to the state after the coming edge.
    task automatic step();
        int                 g;
        int                 c;
        int                 best;
        bit [2:0]           rdy;
        logic [reg_num-1:0] ep;
        @(negedge clk);
        #1;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            c = (m_rr + k) % 3;
            if (m_full[c]) begin
                g = c;
                break;
            end
        end
        if (g >= 0) begin
            best = g;
            for (int j = 0; j < 3; j++) begin
                if (m_full[j] && m_rd[j] == m_rd[g] && m_age[j] < m_age[best]) best = j;
            end
            g = best;
        end
        for (int i = 0; i < 3; i++) rdy[i] = rst_n && (!m_full[i] || g == i);
        ep = '0;
        for (int i = 0; i < 3; i++) if (m_full[i]) ep[m_rd[i]] = 1'b1;
        if (m_we) ep[m_rdo] = 1'b1;

        check("alu_ready", 64'(alu_ready), 64'(rdy[0]));
        check("mem_ready", 64'(mem_ready), 64'(rdy[1]));
        check("lnk_ready", 64'(lnk_ready), 64'(rdy[2]));
        check("pend", 64'(pend), 64'(ep));
        check("pc_wr_err", 64'(pc_wr_err), 64'(m_err));
        check("WE", 64'(we), 64'(m_we));
`ifdef REGWR_BYPASS_EN
        check("byp", 64'({byp_valid, byp_rd, byp_data}), 64'({m_we, m_rdo, m_wb}));
`else
        check("byp", 64'({byp_valid, byp_rd, byp_data}), 64'(0));
`endif

        if (!rst_n) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_we  = 1;
                m_rdo = m_rd[g];
                m_wb  = m_data[g];
                exp_q.push_back('{m_rd[g], m_data[g]});
                m_full[g] = 0;
                m_rr = (g + 1) % 3;
            end else begin
                m_we = 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (v[i] && rdy[i]) begin
                    if (rdi[i] == dir'(reg_num - 1)) begin
                        m_err = 1;
                    end else begin
                        m_full[i] = 1;
                        m_rd[i]   = rdi[i];
                        m_data[i] = di[i];
                        m_age[i]  = m_seq;
                        m_seq++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drive(input int i, input logic [dir-1:0] rd, input logic [bus-1:0] data);
        v[i]   = 1'b1;
        rdi[i] = rd;
        di[i]  = data;
    endtask

    initial begin
        m_seq = 0;
        model_reset();
        for (int r = 0; r < reg_num; r++) bank[r] = '0;
        for (int i = 0; i < 3; i++) begin
            v[i]   = 1'b0;
            rdi[i] = '0;
            di[i]  = '0;
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        idle(1);

        // Single ALU write.
        drive(0, 4'd3, 32'hDEADBEEF);
        step();
        idle(4);
        check("bank_r3", 64'(bank[3]), 64'h0000_0000_DEAD_BEEF);

        // All three requesters streaming for 9 cycles.
        for (int k = 0; k < 9; k++) begin
            drive(0, 4'd1, $urandom);
            drive(1, 4'd2, $urandom);
            drive(2, 4'd4, $urandom);
            step();
        end
        idle(5);

        // Park rr at 2 with a lone mem write, then a same-cycle rd=5 collision.
        drive(1, 4'd7, 32'h77);
        step();
        idle(3);
        drive(1, 4'd5, 32'h11);
        drive(2, 4'd5, 32'h22);
        step();
        idle(4);
        check("bank_r5", 64'(bank[5]), 64'h22);

        // PC-targeted request, then more traffic.
        drive(2, 4'd15, 32'hBAD);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(k % 3, 4'(k), $urandom);
            step();
        end
        idle(4);
        check("pc_err_sticky", 64'(pc_wr_err), 64'd1);

        // Fill all slots, then reset with them full.
        drive(0, 4'd8, 32'hA0);
        drive(1, 4'd9, 32'hA1);
        drive(2, 4'd10, 32'hA2);
        step();
        idle(0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(4);
        check("pc_err_cleared", 64'(pc_wr_err), 64'd0);

        // Randomized traffic with occasional resets and PC targets.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                v[i]   = 1'($urandom_range(0, 1));
                rdi[i] = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
                di[i]  = $urandom;
            end
            rst_n = ($urandom_range(0, 63) != 0);
            step();
        end
        rst_n = 1'b1;
        idle(6);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Write-port arbiter and pending-write scoreboard for the processor register bank. Three writeback sources share the bank's single write port (`WE`/`RD`/`WB`): ALU writeback, memory-load writeback and kernel link. Each source has a one-entry holding slot behind a valid/ready handshake. The arbiter issues at most one write per cycle through a registered output stage and exports a per-register pending mask that decode uses for stall detection.

## Interface
Parameters:
- `bus`, 32, data width
- `dir`, 4, register address width; `reg_num = 2**dir` registers; the top index (`reg_num-1`, PC) is not writable through this block

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`
- `alu_valid`, `alu_rd`, `alu_data`  in  1/`dir`/`bus`  requester 0
- `alu_ready`  out  1  requester 0 may transfer
- `mem_valid`, `mem_rd`, `mem_data`  in  1/`dir`/`bus`  requester 1
- `mem_ready`  out  1
- `lnk_valid`, `lnk_rd`, `lnk_data`  in  1/`dir`/`bus`  requester 2
- `lnk_ready`  out  1
- `WE`  out  1  registered write enable to the register bank
- `RD`  out  `dir`  registered write address
- `WB`  out  `bus`  registered write data
- `pend`  out  `reg_num`  bit r set while a write to r is held in a slot or present on the output stage
- `pc_wr_err`  out  1  sticky; a request targeted the PC index
- `byp_valid`, `byp_rd`, `byp_data`  out  1/`dir`/`bus`  forwarding port (see Configuration)

## Operation
- Transfer on requester i when `valid_i & ready_i` at posedge. The slot captures rd/data and is full from the next cycle.
- `ready_i` is high when slot i is empty or slot i is granted this cycle. This allows back-to-back transfers, one per cycle per requester. `ready_i` is never high during reset.
- A request with rd = `reg_num-1` is accepted (ready follows the normal rule) but never loaded into the slot. `pc_wr_err` is set to 1 and stays set until reset.
- Grant (combinational over full slots), evaluated each cycle:
  - Round-robin pointer `rr` in {0,1,2}. Candidate order: rr, rr+1, rr+2 (mod 3).
  - Ordering override: if the round-robin candidate's rd matches another full slot that is older, the oldest matching slot is granted instead.
  - Age is tracked by a 3x3 age matrix updated on load. For loads in the same cycle, the older slot is the lower requester index.
  - After a grant to slot g, `rr` <= (g+1) mod 3. With no grant, `rr` holds.
- Output stage at posedge:
  - With a grant, `WE`<=1 and `RD`/`WB` <= granted slot; the slot is cleared unless it reloads in the same edge.
  - Without a grant, `WE`<=0 and `RD`/`WB` hold.
- `pend[r]` = OR over full slots with rd==r, OR (`WE` & `RD`==r). It is purely a function of registered state, with no combinational path from the valid inputs.
- Reset (rst_n=0 at posedge), taking precedence over everything:
  - All slots become empty, with any held writes discarded.
  - `rr`=0, age matrix cleared.
  - `WE`=0, `RD`=0, `WB`=0, `pend`=0, `pc_wr_err`=0, `byp_*`=0.
  - A reset mid-operation discards all held writes; no write is emitted on the edge following reset.

## Timing
- Latency: transfer at edge N, earliest `WE`=1 during cycle N+1→N+2; the bank commits at edge N+2.
- Throughput: one write per cycle sustained. With k slots full, the last one issues within k cycles.
- Starvation bound: a full slot is granted within 3 cycles.
- Writes to the same rd issue in acceptance order. Different-rd writes may reorder.
- `pend[r]` rises the cycle after acceptance. It falls the cycle after `WE` deasserts or `RD` changes away from r.

## Configuration
- `REGWR_BYPASS_EN` defined:
  - `byp_valid`=`WE`, `byp_rd`=`RD`, `byp_data`=`WB`, all combinationally from the output register.
  - This lets readers forward the value the bank is writing this cycle. For `pend[r]` set only by the output stage, readers may forward instead of stalling.
- `REGWR_BYPASS_EN` undefined: `byp_valid`, `byp_rd` and `byp_data` are constant 0. Behaviour is otherwise identical.

## Test plan
- Reset, then single ALU write rd=3 data=0xDEADBEEF → `pend[3]`=1 next cycle; `WE`=1, `RD`=3, `WB`=0xDEADBEEF two cycles after transfer; `pend`=0 after.
- All three requesters valid every cycle for 9 cycles (rd=1,2,4) → `WE` continuously 1; grants rotate 0,1,2,0,…; each ready duty-cycled; no lost or duplicated writes.
- Same-cycle mem rd=5=0x11 and lnk rd=5=0x22, rr=2 → mem (lower index, older) issues first, then lnk; the bank ends with 0x22.
- lnk_rd=15 valid → accepted, no `WE`, `pc_wr_err`=1 and stays 1 through later traffic until `rst_n`=0.
- Three slots full, assert `rst_n`=0 for one edge → `WE`=0, `pend`=0 and all ready=0 during reset; no held write emitted afterward.
- Bypass: with `REGWR_BYPASS_EN` defined, `byp_*` mirrors `WE`/`RD`/`WB` every cycle; with it undefined, `byp_*`=0 throughout.
